// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads 16-bit instructions as two bytes (high first) from a
// byte-wide memory port, hands them to the core over valid/ready, and owns the PC.
module inst_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [15:0]       inst,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] link_pc
);

    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        HOLD,
        DRAIN
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] tgt_q, tgt_n;
    logic [7:0]        hi_q, hi_n;

    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              inst_valid_n;
    logic [15:0]       inst_n;
    logic [3:0]        opcode_n;
    logic [ADDR_W-1:0] inst_pc_n;
    logic [ADDR_W-1:0] link_pc_n;

    // NOTE: every signal assigned here gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred; blocking '=' is correct inside always_comb.
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        tgt_n        = tgt_q;
        hi_n         = hi_q;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;
        inst_valid_n = inst_valid;
        inst_n       = inst;
        opcode_n     = opcode;
        inst_pc_n    = inst_pc;
        link_pc_n    = link_pc;

        if (redirect) begin
            // An outstanding request cannot be withdrawn, so park the target until it acks.
            if (mem_req && !mem_ack) begin
                tgt_n        = redirect_pc;
                inst_valid_n = 1'b0;
                state_n      = DRAIN;
            end else begin
                pc_n         = redirect_pc;
                inst_valid_n = 1'b0;
                mem_req_n    = !stall;
                mem_addr_n   = redirect_pc;
                state_n      = FETCH_HI;
            end
        end else begin
            case (state_q)
                FETCH_HI: begin
                    if (!mem_req) begin
                        if (!stall) begin
                            mem_req_n  = 1'b1;
                            mem_addr_n = pc_q;
                        end
                    end else if (mem_ack) begin
                        hi_n       = mem_rdata;
                        mem_addr_n = pc_q + ADDR_W'(1);
                        state_n    = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        inst_n       = {hi_q, mem_rdata};
                        opcode_n     = hi_q[7:4];
                        inst_pc_n    = pc_q;
                        link_pc_n    = pc_q + ADDR_W'(2);
                        inst_valid_n = 1'b1;
                        mem_req_n    = 1'b0;
                        state_n      = HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid_n = 1'b0;
                        pc_n         = pc_q + ADDR_W'(2);
                        mem_req_n    = !stall;
                        mem_addr_n   = pc_q + ADDR_W'(2);
                        state_n      = FETCH_HI;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req_n = 1'b0;
                        pc_n      = tgt_q;
                        state_n   = FETCH_HI;
                    end
                end
                default: state_n = FETCH_HI;
            endcase
        end
    end

    // NOTE: state updates use non-blocking '<=' so all registers sample the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_HI;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            hi_q       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            opcode     <= '0;
            inst_pc    <= RESET_PC;
            link_pc    <= RESET_PC + ADDR_W'(2);
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            tgt_q      <= tgt_n;
            hi_q       <= hi_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            inst_valid <= inst_valid_n;
            inst       <= inst_n;
            opcode     <= opcode_n;
            inst_pc    <= inst_pc_n;
            link_pc    <= link_pc_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory with programmable ack latency and a
// linear sequence of steps checked with immediate assertions.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [3:0]  opcode;
    logic [7:0]  inst_pc;
    logic [7:0]  link_pc;

    logic [7:0]  mem [256];
    int          lat;
    int          wait_cnt;
    int          tests;
    int          failed;

    inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .opcode     (opcode),
        .inst_pc    (inst_pc),
        .link_pc    (link_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks once a request has been waiting `lat` cycles (lat=0: same cycle).
    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        lat         = 0;
        wait_cnt    = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        inst_ready  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
        mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
        mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
        mem[8'h06] = 8'hDE; mem[8'h07] = 8'hF0;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'h23;
        mem[8'hFF] = 8'hC7;

        // Reset state
        #12;
        check("rst_mem_req",    16'(mem_req),    16'h0);
        check("rst_mem_addr",   16'(mem_addr),   16'h00);
        check("rst_inst_valid", 16'(inst_valid), 16'h0);
        check("rst_inst",       inst,            16'h0000);
        check("rst_opcode",     16'(opcode),     16'h0);
        check("rst_inst_pc",    16'(inst_pc),    16'h00);
        check("rst_link_pc",    16'(link_pc),    16'h02);
        rst_n = 1'b1;

        // Zero-wait fetch of 0x1234
        tick();
        check("e1_mem_req",  16'(mem_req),  16'h1);
        check("e1_mem_addr", 16'(mem_addr), 16'h00);
        tick();
        check("e2_mem_addr", 16'(mem_addr), 16'h01);
        check("e2_valid",    16'(inst_valid), 16'h0);
        tick();
        check("e3_valid",    16'(inst_valid), 16'h1);
        check("e3_inst",     inst,            16'h1234);
        check("e3_opcode",   16'(opcode),     16'h1);
        check("e3_inst_pc",  16'(inst_pc),    16'h00);
        check("e3_link_pc",  16'(link_pc),    16'h02);
        check("e3_mem_req",  16'(mem_req),    16'h0);
        tick();
        check("e4_mem_req",  16'(mem_req),  16'h1);
        check("e4_mem_addr", 16'(mem_addr), 16'h02);
        check("e4_valid",    16'(inst_valid), 16'h0);

        // Back-pressure on the second instruction
        tick();
        check("bp_lo_addr", 16'(mem_addr), 16'h03);
        inst_ready = 1'b0;
        tick();
        check("bp_valid", 16'(inst_valid), 16'h1);
        check("bp_inst",  inst,            16'h5678);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid",   16'(inst_valid), 16'h1);
            check("bp_hold_inst",    inst,            16'h5678);
            check("bp_hold_opcode",  16'(opcode),     16'h5);
            check("bp_hold_inst_pc", 16'(inst_pc),    16'h02);
            check("bp_hold_mem_req", 16'(mem_req),    16'h0);
        end
        inst_ready = 1'b1;
        tick();
        check("bp_resume_req",   16'(mem_req),    16'h1);
        check("bp_resume_addr",  16'(mem_addr),   16'h04);
        check("bp_resume_valid", 16'(inst_valid), 16'h0);
        tick();
        tick();
        check("i3_inst",    inst,         16'h9ABC);
        check("i3_inst_pc", 16'(inst_pc), 16'h04);

        // Stall held while no request is outstanding
        stall = 1'b1;
        tick();
        check("st_req_low",   16'(mem_req),    16'h0);
        check("st_valid_low", 16'(inst_valid), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_wait_req", 16'(mem_req), 16'h0);
        end

        // Stall rising after the request is issued, 3-cycle ack latency
        stall = 1'b0;
        lat   = 3;
        tick();
        check("sl_req",  16'(mem_req),  16'h1);
        check("sl_addr", 16'(mem_addr), 16'h06);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sl_hold_req",  16'(mem_req),  16'h1);
            check("sl_hold_addr", 16'(mem_addr), 16'h06);
        end
        tick();
        check("sl_lo_req",  16'(mem_req),  16'h1);
        check("sl_lo_addr", 16'(mem_addr), 16'h07);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sl_lo_wait_valid", 16'(inst_valid), 16'h0);
        end
        tick();
        check("sl_valid",   16'(inst_valid), 16'h1);
        check("sl_inst",    inst,            16'hDEF0);
        check("sl_opcode",  16'(opcode),     16'hD);
        check("sl_inst_pc", 16'(inst_pc),    16'h06);
        check("sl_link_pc", 16'(link_pc),    16'h08);
        tick();
        check("sl_accept_req", 16'(mem_req), 16'h0);

        // Redirect while the hi-byte request is outstanding, ack after 2 cycles
        stall = 1'b0;
        lat   = 2;
        tick();
        check("rd_req",  16'(mem_req),  16'h1);
        check("rd_addr", 16'(mem_addr), 16'h08);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        check("rd_drain_req",   16'(mem_req),    16'h1);
        check("rd_drain_addr",  16'(mem_addr),   16'h08);
        check("rd_drain_valid", 16'(inst_valid), 16'h0);
        tick();
        check("rd_drain2_addr", 16'(mem_addr), 16'h08);
        tick();
        check("rd_ack_req", 16'(mem_req), 16'h0);
        tick();
        check("rd_new_req",  16'(mem_req),  16'h1);
        check("rd_new_addr", 16'(mem_addr), 16'h40);

        // Second redirect while draining overwrites the target
        redirect    = 1'b1;
        redirect_pc = 8'h44;
        tick();
        check("rd2_drain_addr", 16'(mem_addr), 16'h40);
        redirect_pc = 8'h50;
        tick();
        redirect = 1'b0;
        check("rd2_drain2_addr", 16'(mem_addr), 16'h40);
        tick();
        check("rd2_ack_req", 16'(mem_req), 16'h0);
        tick();
        check("rd2_new_req",  16'(mem_req),  16'h1);
        check("rd2_new_addr", 16'(mem_addr), 16'h50);

        // Redirect coinciding with ack: no drain
        lat         = 0;
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        check("ra_req",  16'(mem_req),  16'h1);
        check("ra_addr", 16'(mem_addr), 16'h10);
        tick();
        check("ra_lo_addr", 16'(mem_addr), 16'h11);
        tick();
        check("ra_valid",   16'(inst_valid), 16'h1);
        check("ra_inst",    inst,            16'hA123);
        check("ra_opcode",  16'(opcode),     16'hA);
        check("ra_inst_pc", 16'(inst_pc),    16'h10);
        check("ra_link_pc", 16'(link_pc),    16'h12);

        // Redirect coinciding with inst_ready in HOLD
        redirect    = 1'b1;
        redirect_pc = 8'h30;
        tick();
        check("rh_req",   16'(mem_req),    16'h1);
        check("rh_addr",  16'(mem_addr),   16'h30);
        check("rh_valid", 16'(inst_valid), 16'h0);

        // Wrap at the top of the address space
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        check("wr_hi_addr", 16'(mem_addr), 16'hFF);
        tick();
        check("wr_lo_addr", 16'(mem_addr), 16'h00);
        tick();
        check("wr_valid",   16'(inst_valid), 16'h1);
        check("wr_inst",    inst,            16'hC712);
        check("wr_opcode",  16'(opcode),     16'hC);
        check("wr_inst_pc", 16'(inst_pc),    16'hFF);
        check("wr_link_pc", 16'(link_pc),    16'h01);
        tick();
        check("wr_next_req",  16'(mem_req),  16'h1);
        check("wr_next_addr", 16'(mem_addr), 16'h01);
        tick();
        check("wr_next_lo_addr", 16'(mem_addr), 16'h02);

        // Asynchronous reset in FETCH_LO
        rst_n = 1'b0;
        #1;
        check("ar_mem_req",    16'(mem_req),    16'h0);
        check("ar_mem_addr",   16'(mem_addr),   16'h00);
        check("ar_inst_valid", 16'(inst_valid), 16'h0);
        check("ar_inst",       inst,            16'h0000);
        check("ar_opcode",     16'(opcode),     16'h0);
        check("ar_inst_pc",    16'(inst_pc),    16'h00);
        check("ar_link_pc",    16'(link_pc),    16'h02);
        rst_n = 1'b1;
        tick();
        check("ar_refetch_req",  16'(mem_req),  16'h1);
        check("ar_refetch_addr", 16'(mem_addr), 16'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
